// File: rtl/edge_gen_pkg.sv
// Shared definitions for the edge generator: default sizing, the FSM state
// encoding and small state-decoding helpers used by the top level.
package edge_gen_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_MIN_HIGH = 4;
    localparam int DEF_MIN_LOW  = 4;

    typedef enum logic [2:0] {
        ST_IDLE_LOW  = 3'd0,
        ST_HIGH_HOLD = 3'd1,
        ST_IDLE_HIGH = 3'd2,
        ST_LOW_HOLD  = 3'd3,
        ST_PULSE     = 3'd4
    } edge_state_t;

    // Level driven on edge_signal while the FSM sits in the given state.
    function automatic logic state_is_high(input edge_state_t st);
        logic high_v;
        case (st)
            ST_HIGH_HOLD,
            ST_IDLE_HIGH,
            ST_PULSE:     high_v = 1'b1;
            default:      high_v = 1'b0;
        endcase
        return high_v;
    endfunction

    // Any state other than the two idle states is a timed (busy) state.
    function automatic logic state_is_busy(input edge_state_t st);
        logic busy_v;
        case (st)
            ST_IDLE_LOW,
            ST_IDLE_HIGH: busy_v = 1'b0;
            default:      busy_v = 1'b1;
        endcase
        return busy_v;
    endfunction

endpackage

// File: rtl/edge_generator_hold_counter.sv
// Loadable down-counter timing hold and pulse intervals. A load wins over a
// decrement; the count saturates at zero so it can never wrap.
module hold_counter
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             at_one
);

    logic [CNT_W-1:0] value_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= {CNT_W{1'b0}};
        end else if (load) begin
            value_r <= load_value;
        end else if (dec && (value_r != {CNT_W{1'b0}})) begin
            value_r <= value_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            value_r <= value_r;
        end
    end

    assign value  = value_r;
    assign at_one = (value_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/edge_generator.sv
// Edge generator: produces a level with guaranteed minimum high/low hold
// times, optional self-terminating pulses, and completion/drop strobes.
// Requests arriving during a hold are queued as pending (one per type) and
// served when the hold expires; anything that cannot be queued is dropped.
module edge_generator
    import edge_gen_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MIN_HIGH = DEF_MIN_HIGH,
    parameter int MIN_LOW  = DEF_MIN_LOW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rise_req,
    input  logic             fall_req,
    input  logic             pulse_req,
    input  logic [CNT_W-1:0] pulse_len,
    output logic             edge_signal,
    output logic             rise_done,
    output logic             fall_done,
    output logic             busy,
    output logic             req_dropped
);

    localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MIN_LOW_C  = CNT_W'(MIN_LOW);

    // A pulse is never shorter than the minimum high time (covers length 0).
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        logic [CNT_W-1:0] res_v;
        if (len < MIN_HIGH_C) begin
            res_v = MIN_HIGH_C;
        end else begin
            res_v = len;
        end
        return res_v;
    endfunction

    edge_state_t      state_r;
    edge_state_t      state_next_s;

    logic             pend_rise_r;
    logic             pend_fall_r;
    logic             pend_pulse_r;
    logic [CNT_W-1:0] pend_len_r;
    logic             pend_rise_next_s;
    logic             pend_fall_next_s;
    logic             pend_pulse_next_s;
    logic [CNT_W-1:0] pend_len_next_s;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_value_s;
    logic             cnt_at_one_s;
    logic             cnt_done_s;

    logic             drop_s;
    logic             next_high_s;

    logic             edge_r;
    logic             rise_done_r;
    logic             fall_done_r;
    logic             busy_r;
    logic             dropped_r;

    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load_s),
        .load_value (cnt_load_val_s),
        .dec        (cnt_dec_s),
        .value      (cnt_value_s),
        .at_one     (cnt_at_one_s)
    );

    // A hold also ends if the count is ever found at zero, so a timed state
    // can never stall.
    assign cnt_done_s = cnt_at_one_s | (cnt_value_s == {CNT_W{1'b0}});

    // Next-state, counter control, pending-request bookkeeping and drop detection.
    always_comb begin
        state_next_s      = state_r;
        pend_rise_next_s  = pend_rise_r;
        pend_fall_next_s  = pend_fall_r;
        pend_pulse_next_s = pend_pulse_r;
        pend_len_next_s   = pend_len_r;
        cnt_load_s        = 1'b0;
        cnt_load_val_s    = {CNT_W{1'b0}};
        cnt_dec_s         = 1'b0;
        drop_s            = 1'b0;

        case (state_r)
            ST_IDLE_LOW: begin
                if (pulse_req) begin
                    state_next_s   = ST_PULSE;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = clamp_len(pulse_len);
                    drop_s         = rise_req | fall_req;
                end else if (rise_req) begin
                    // A simultaneous fall becomes a minimum-width pulse.
                    state_next_s     = ST_HIGH_HOLD;
                    cnt_load_s       = 1'b1;
                    cnt_load_val_s   = MIN_HIGH_C;
                    pend_fall_next_s = fall_req;
                end else if (fall_req) begin
                    drop_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE_LOW;
                end
            end

            ST_HIGH_HOLD: begin
                drop_s = rise_req | pulse_req;
                if (fall_req) begin
                    if (pend_fall_r) begin
                        drop_s = 1'b1;
                    end else begin
                        pend_fall_next_s = 1'b1;
                    end
                end else begin
                    pend_fall_next_s = pend_fall_r;
                end
                if (cnt_done_s) begin
                    if (pend_fall_next_s) begin
                        state_next_s     = ST_LOW_HOLD;
                        cnt_load_s       = 1'b1;
                        cnt_load_val_s   = MIN_LOW_C;
                        pend_fall_next_s = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE_HIGH;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end

            ST_IDLE_HIGH: begin
                drop_s = rise_req | pulse_req;
                if (fall_req) begin
                    state_next_s   = ST_LOW_HOLD;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = MIN_LOW_C;
                end else begin
                    state_next_s = ST_IDLE_HIGH;
                end
            end

            ST_LOW_HOLD: begin
                drop_s = fall_req;
                if (rise_req) begin
                    if (pend_rise_r) begin
                        drop_s = 1'b1;
                    end else begin
                        pend_rise_next_s = 1'b1;
                    end
                end else begin
                    pend_rise_next_s = pend_rise_r;
                end
                if (pulse_req) begin
                    if (pend_pulse_r) begin
                        drop_s = 1'b1;
                    end else begin
                        pend_pulse_next_s = 1'b1;
                        pend_len_next_s   = pulse_len;
                    end
                end else begin
                    pend_pulse_next_s = pend_pulse_r;
                end
                if (cnt_done_s) begin
                    if (pend_pulse_next_s) begin
                        state_next_s   = ST_PULSE;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = clamp_len(pend_len_next_s);
                    end else if (pend_rise_next_s) begin
                        state_next_s   = ST_HIGH_HOLD;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = MIN_HIGH_C;
                    end else begin
                        state_next_s = ST_IDLE_LOW;
                    end
                    pend_rise_next_s  = 1'b0;
                    pend_pulse_next_s = 1'b0;
                    pend_fall_next_s  = 1'b0;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end

            ST_PULSE: begin
                drop_s = rise_req | fall_req | pulse_req;
                if (cnt_done_s) begin
                    state_next_s   = ST_LOW_HOLD;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = MIN_LOW_C;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end

            default: begin
                state_next_s      = ST_IDLE_LOW;
                pend_rise_next_s  = 1'b0;
                pend_fall_next_s  = 1'b0;
                pend_pulse_next_s = 1'b0;
            end
        endcase
    end

    assign next_high_s = state_is_high(state_next_s);

    // State and pending-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE_LOW;
            pend_rise_r  <= 1'b0;
            pend_fall_r  <= 1'b0;
            pend_pulse_r <= 1'b0;
            pend_len_r   <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            pend_rise_r  <= pend_rise_next_s;
            pend_fall_r  <= pend_fall_next_s;
            pend_pulse_r <= pend_pulse_next_s;
            pend_len_r   <= pend_len_next_s;
        end
    end

    // Output flops: level and strobes are decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_r      <= 1'b0;
            rise_done_r <= 1'b0;
            fall_done_r <= 1'b0;
            busy_r      <= 1'b0;
            dropped_r   <= 1'b0;
        end else begin
            edge_r      <= next_high_s;
            rise_done_r <= next_high_s & ~edge_r;
            fall_done_r <= ~next_high_s & edge_r;
            busy_r      <= state_is_busy(state_next_s);
            dropped_r   <= drop_s;
        end
    end

    assign edge_signal = edge_r;
    assign rise_done   = rise_done_r;
    assign fall_done   = fall_done_r;
    assign busy        = busy_r;
    assign req_dropped = dropped_r;

endmodule

// File: tb/tb_edge_generator.sv
// Self-checking bench for edge_generator (MIN_HIGH = MIN_LOW = 4). Each
// scenario starts from reset; the expected output vector for every cycle is
// derived from hand-computed timelines and queued when the stimulus for the
// preceding cycle is driven, then popped and compared after the clock edge.
module tb_edge_generator;
    import edge_gen_pkg::*;

    localparam int CNT_W = DEF_CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rise_req = 1'b0;
    logic             fall_req = 1'b0;
    logic             pulse_req = 1'b0;
    logic [CNT_W-1:0] pulse_len = '0;
    logic             edge_signal;
    logic             rise_done;
    logic             fall_done;
    logic             busy;
    logic             req_dropped;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         sc;
        int         cyc;
        logic [4:0] v;
    } exp_t;

    exp_t sb_q[$];

    edge_generator #(
        .CNT_W    (CNT_W),
        .MIN_HIGH (4),
        .MIN_LOW  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rise_req    (rise_req),
        .fall_req    (fall_req),
        .pulse_req   (pulse_req),
        .pulse_len   (pulse_len),
        .edge_signal (edge_signal),
        .rise_done   (rise_done),
        .fall_done   (fall_done),
        .busy        (busy),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge,rise_done,fall_done,busy,dropped)",
                     tag, act, exp);
        end
    endtask

    function automatic bit in_rng(input int k, input int a, input int b);
        return (k >= a) && (k <= b);
    endfunction

    // Expected {edge_signal, rise_done, fall_done, busy, req_dropped} in cycle k.
    function automatic logic [4:0] exp_out(input int sc, input int k);
        bit e, r, f, b, d;
        e = 1'b0; r = 1'b0; f = 1'b0; b = 1'b0; d = 1'b0;
        case (sc)
            1: begin e = in_rng(k, 11, 20); r = (k == 11); f = (k == 21);
                     b = in_rng(k, 11, 14) || in_rng(k, 21, 24); end
            2: begin e = in_rng(k, 6, 9); r = (k == 6); f = (k == 10); b = in_rng(k, 6, 13); end
            3: begin e = in_rng(k, 4, 13); r = (k == 4); f = (k == 14); b = in_rng(k, 4, 17); end
            4, 7: begin e = in_rng(k, 4, 7); r = (k == 4); f = (k == 8); b = in_rng(k, 4, 11); end
            5: begin d = (k == 3); end
            6: begin e = in_rng(k, 3, 22) && !in_rng(k, 11, 14);
                     r = (k == 3) || (k == 15); f = (k == 11) || (k == 23);
                     b = in_rng(k, 3, 6) || in_rng(k, 11, 18) || in_rng(k, 23, 26);
                     d = (k == 9) || (k == 21); end
            8: begin e = in_rng(k, 2, 7); r = (k == 2); f = (k == 8); b = in_rng(k, 2, 11);
                     d = (k == 4) || (k == 6); end
            9: begin e = in_rng(k, 2, 5); r = (k == 2); f = (k == 6); b = in_rng(k, 2, 9);
                     d = (k == 3) || (k == 4); end
            10: begin e = in_rng(k, 2, 5) || in_rng(k, 10, 14); r = (k == 2) || (k == 10);
                      f = (k == 6) || (k == 15); b = in_rng(k, 2, 18); end
            11: begin e = in_rng(k, 4, 7) || (k >= 9); r = (k == 4) || (k == 9);
                      b = in_rng(k, 4, 7) || in_rng(k, 9, 12); end
            default: begin e = 1'b0; end
        endcase
        return {e, r, f, b, d};
    endfunction

    // Drive the request inputs for cycle k of scenario sc.
    task automatic drive_stim(input int sc, input int k);
        rise_req  = 1'b0;
        fall_req  = 1'b0;
        pulse_req = 1'b0;
        pulse_len = CNT_W'($urandom_range(0, 65535));
        case (sc)
            1: begin rise_req = (k == 10); fall_req = (k == 20); end
            2: begin rise_req = (k == 5); fall_req = (k == 5); end
            3: if (k == 3) begin pulse_req = 1'b1; pulse_len = CNT_W'(10); end
            4: if (k == 3) begin pulse_req = 1'b1; pulse_len = CNT_W'(2); end
            5: fall_req = (k == 2);
            6: begin rise_req = (k == 2) || (k == 8) || (k == 12); fall_req = (k == 10) || (k == 22);
                     pulse_req = (k == 20); end
            7: if (k == 3) begin pulse_req = 1'b1; pulse_len = CNT_W'(0); end
            8: begin if (k == 1) begin pulse_req = 1'b1; pulse_len = CNT_W'(6); end
                     rise_req = (k == 3); fall_req = (k == 5); end
            9: begin rise_req = (k == 1) || (k == 3); fall_req = (k == 1) || (k == 2); end
            10: begin rise_req = (k == 1) || (k == 8); fall_req = (k == 1);
                      if (k == 7) begin pulse_req = 1'b1; pulse_len = CNT_W'(5); end end
            11: begin if (k == 3) begin pulse_req = 1'b1; pulse_len = CNT_W'(10); end
                      rise_req = (k == 8); end
            default: rise_req = 1'b0;
        endcase
    endtask

    task automatic pop_check();
        exp_t x;
        logic [4:0] act;
        act = {edge_signal, rise_done, fall_done, busy, req_dropped};
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_eq($sformatf("sc%0d_cyc%0d", x.sc, x.cyc), 32'(act), 32'(x.v));
        end
    endtask

    // Hold reset for two edges, check the reset state, release just after an edge.
    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        rise_req = 1'b0; fall_req = 1'b0; pulse_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_state", 32'({edge_signal, rise_done, fall_done, busy, req_dropped}), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_sc(input int sc, input int len);
        apply_reset();
        sb_q.push_back('{sc, 0, exp_out(sc, 0)});
        pop_check();
        for (int k = 0; k < len; k++) begin
            if (sc == 11 && k == 7) begin
                rst_n = 1'b0;
                #1;
                check_eq("sc11_async_rst",
                         32'({edge_signal, rise_done, fall_done, busy, req_dropped}), 32'd0);
            end
            if (sc == 11 && k == 8) begin
                rst_n = 1'b1;
            end
            drive_stim(sc, k);
            sb_q.push_back('{sc, k + 1, exp_out(sc, k + 1)});
            @(posedge clk); #1;
            pop_check();
        end
        rise_req = 1'b0; fall_req = 1'b0; pulse_req = 1'b0;
    endtask

    initial begin
        int run_len [1:11];
        run_len = '{27, 16, 20, 14, 6, 28, 14, 13, 12, 21, 15};
        for (int sc = 1; sc <= 11; sc++) begin
            run_sc(sc, run_len[sc]);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_generator.md
EDGE_GENERATOR -- requirements
Module: edge_generator

Interface
REQ-001 Parameter CNT_W, default 16, width of the hold counter and the pulse_len input.
REQ-002 Parameter MIN_HIGH, default 4, minimum number of cycles edge_signal stays high after a rising edge (legal range 1..2^CNT_W-1).
REQ-003 Parameter MIN_LOW, default 4, minimum number of cycles edge_signal stays low after a falling edge (legal range 1..2^CNT_W-1).
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rise_req  input  1  one-cycle strobe requesting a rising edge on edge_signal.
REQ-007 fall_req  input  1  one-cycle strobe requesting a falling edge on edge_signal.
REQ-008 pulse_req  input  1  one-cycle strobe requesting a self-terminating high pulse.
REQ-009 pulse_len  input  CNT_W  pulse high time in cycles; sampled only in the cycle pulse_req is accepted.
REQ-010 edge_signal  output  1  generated level, driven directly from a flop.
REQ-011 rise_done  output  1  one-cycle strobe in the first cycle edge_signal is 1 after being 0.
REQ-012 fall_done  output  1  one-cycle strobe in the first cycle edge_signal is 0 after being 1.
REQ-013 busy  output  1  high in every state except IDLE_LOW and IDLE_HIGH.
REQ-014 req_dropped  output  1  one-cycle strobe, asserted one cycle after an ignored request.

Function
REQ-015 The FSM SHALL have five states: IDLE_LOW, HIGH_HOLD, IDLE_HIGH, LOW_HOLD, PULSE.
REQ-016 Latency: a request accepted at clock edge N SHALL produce the edge_signal transition visible from edge N onward (registered, one-cycle latency); rise_done/fall_done SHALL assert in the same cycle as the transition.
REQ-017 IDLE_LOW: pulse_req has priority over rise_req; rise_req -> HIGH_HOLD with counter loaded to MIN_HIGH; pulse_req -> PULSE with counter loaded to max(pulse_len, MIN_HIGH); fall_req alone is ignored and SHALL strobe req_dropped.
REQ-018 IDLE_LOW with rise_req and fall_req together: rise accepted, fall latched as pending (yields a MIN_HIGH-cycle pulse); no req_dropped.
REQ-019 HIGH_HOLD: counter decrements each cycle; fall_req sets pending_fall; at count 1, pending_fall -> LOW_HOLD (counter = MIN_LOW, pending cleared), else -> IDLE_HIGH.
REQ-020 IDLE_HIGH: fall_req -> LOW_HOLD with counter = MIN_LOW; rise_req or pulse_req ignored with req_dropped.
REQ-021 LOW_HOLD: counter decrements; rise_req sets pending_rise; pulse_req sets pending_pulse and latches pulse_len; at count 1, pending_pulse -> PULSE, else pending_rise -> HIGH_HOLD, else -> IDLE_LOW; all pending flags then cleared.
REQ-022 PULSE: edge_signal high; counter decrements; at count 1 -> LOW_HOLD (counter = MIN_LOW); any rise_req, fall_req or pulse_req in PULSE SHALL be ignored with req_dropped.
REQ-023 A second request of an already pending type SHALL be ignored with req_dropped; the pending request is kept.
REQ-024 In HIGH_HOLD, rise_req and pulse_req SHALL be ignored with req_dropped.
REQ-025 pulse_len of 0 SHALL be treated as MIN_HIGH (clamp rule of REQ-017).
REQ-026 edge_signal SHALL be 1 exactly in HIGH_HOLD, IDLE_HIGH and PULSE.
REQ-027 Counter arithmetic is unsigned CNT_W bits; the counter never wraps (reload always occurs at count 1).

Reset
REQ-028 On rst_n low: state IDLE_LOW, edge_signal 0, rise_done 0, fall_done 0, busy 0, req_dropped 0, counter 0, all pending flags 0.
REQ-029 Reset asserted mid-operation SHALL abort any hold or pulse immediately; no fall_done strobe is generated for the forced low.
REQ-030 Requests present in the first cycle after reset release SHALL be processed normally.

Structure
REQ-031 The state enumeration and the default MIN_HIGH/MIN_LOW/CNT_W values SHALL reside in shared package edge_gen_pkg.
REQ-032 The loadable down-counter SHALL be a sub-module hold_counter (load, value, dec, at_one outputs).

Verification (MIN_HIGH=4, MIN_LOW=4)
REQ-033 rise_req at cycle 10, fall_req at 20 -> edge_signal high cycles 11-20, rise_done at 11, fall_done at 21, busy 11-14 and 21-24.
REQ-034 rise_req and fall_req together at cycle 5 -> edge_signal high cycles 6-9, fall_done at 10, no req_dropped.
REQ-035 pulse_req with pulse_len=10 at cycle 3 -> high cycles 4-13; pulse_len=2 -> high cycles 4-7 (clamped).
REQ-036 fall_req at cycle 2 while idle low -> req_dropped at cycle 3, edge_signal stays 0.
REQ-037 fall_req at 10 (from IDLE_HIGH), rise_req at 12 -> low cycles 11-14, edge_signal high again at 15 with rise_done.
REQ-038 rst_n low at cycle 7 during PULSE -> edge_signal 0 at once, state IDLE_LOW, no fall_done; rise_req after release accepted.
